register_file_responder: RTL
============================

// Module: register_file_responder
// PURPOSE
//  Architectural integer register file; the responder end of the writeback-to-regfile interface.
//  - Accepts at most one write per writeback episode: wb_module_enable high with register_write_enable.
//  - Returns wb_write_complete to the writeback stage and exposes the full register array.
//  - Provides two decode read ports and a busy scoreboard. Decode reserves a destination register at issue; the writeback clears it.
// PARAMETERS
//  XLEN      64  data width of each register
//  NUM_REGS  32  register count; the address width is $clog2(NUM_REGS) (5 at default)
//  BYPASS    1   1: read ports forward the write data being accepted this cycle; 0: no forwarding
// PORTS
//  clk                    in   1          rising-edge clock
//  reset                  in   1          asynchronous, active-low reset
//  wb_module_enable       in   1          writeback stage holds a valid instruction
//  register_write_enable  in   1          write request qualifier from writeback
//  register_write_addr    in   5          destination register
//  register_write_data    in   XLEN       write data
//  wb_write_complete      out  1          write accepted; held until wb_module_enable falls
//  register               out  XLEN x32   full register array (ECALL argument access)
//  rs1_addr, rs2_addr     in   5          decode read addresses
//  rs1_data, rs2_data     out  XLEN       combinational read data
//  reserve_enable         in   1          decode issues an instruction with a destination
//  reserve_addr           in   5          destination register being reserved
//  rs1_busy, rs2_busy     out  1          source register has a pending write
//  busy                   out  32         scoreboard vector
//  writes_retired         out  64         count of accepted writes, including discarded x0 writes
// BEHAVIOUR
//  Reset (reset=0, async)
//  - All registers 0, busy 0, writes_retired 0, state IDLE, wb_write_complete 0.
//  FSM states
//  - IDLE: wb_write_complete=0. On a clk edge with wb_module_enable && register_write_enable:
//    - write register_write_data to register_write_addr; addr 0 is discarded.
//    - clear busy[addr]; increment writes_retired.
//    - go to ACK.
//  - IDLE: wb_module_enable high with register_write_enable low (ECALL pending) means stay in IDLE; no write.
//  - ACK: wb_write_complete=1, driven from the state register.
//    - All write requests are ignored, so there is exactly one write per episode.
//    - When wb_module_enable is sampled low, go to IDLE.
//    - Back-to-back instructions must drop wb_module_enable for at least one cycle.
//  Latency and visibility
//  - Write latency is 1 cycle.
//  - wb_write_complete rises on the cycle after the accepting edge.
//  - The register output shows the new value from that same cycle.
//  x0 rules
//  - register[0] always reads 0.
//  - busy[0] is never set.
//  - rs*_data for address 0 is always 0, including under bypass.
//  Reads
//  - rs*_data = register[rs*_addr].
//  - If BYPASS=1 and the FSM is in IDLE with a write qualifying this cycle to the same nonzero address, the read returns register_write_data.
//  Scoreboard
//  - reserve_enable with a nonzero addr sets busy[addr] at the clk edge.
//  - Reserve and clear of the same address on the same edge: reserve wins, busy stays 1.
//  - Reserve and clear of different addresses on the same edge: both take effect.
//  - rs*_busy = busy[rs*_addr], combinational. It is NOT bypassed by the write being accepted this cycle.
//  Counter
//  - writes_retired wraps modulo 2^64.
//  Reset mid-operation
//  - Reset in ACK returns the FSM to IDLE with wb_write_complete 0.
//  - A write in flight on the reset edge is lost.
// TESTING
//  1. After reset: register_write_addr=5, data=64'hDEAD_BEEF, both enables=1.
//     - Next cycle: register[5]=DEAD_BEEF, wb_write_complete=1, writes_retired=1.
//  2. In ACK with wb_module_enable held high, change the write to addr=6, data=1.
//     - register[6] stays 0; wb_write_complete stays 1 until enable drops, then IDLE.
//  3. Write x0 with 64'hFFFF.
//     - register[0]=0, rs1_addr=0 reads 0, wb_write_complete=1, writes_retired increments.
//  4. reserve_enable with addr=7 -> busy[7]=1, rs2_busy=1 (rs2_addr=7).
//     - A later write to x7 clears it.
//     - Simultaneous reserve x7 and write x7 leaves busy[7]=1.
//  5. wb_module_enable=1 with register_write_enable=0 for 4 cycles (ECALL), then register_write_enable=1, data=42, addr=10.
//     - Exactly one write; register[10]=42.
//  6. BYPASS=1, rs1_addr=3 while the IDLE write to x3 = 64'h1234 is accepted -> rs1_data=64'h1234 that cycle.
//     - Assert reset low while in ACK -> wb_write_complete=0 and register[3]=0 immediately.

Source files
------------

// File: rtl/register_file_responder_if.sv
// Writeback-to-regfile handshake: one write request per episode,
// answered by a completion flag held until the enable drops.
interface register_file_responder_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic            wb_module_enable;
    logic            register_write_enable;
    logic [AW-1:0]   register_write_addr;
    logic [XLEN-1:0] register_write_data;
    logic            wb_write_complete;

    modport master (
        output wb_module_enable,
        output register_write_enable,
        output register_write_addr,
        output register_write_data,
        input  wb_write_complete
    );

    modport slave (
        input  wb_module_enable,
        input  register_write_enable,
        input  register_write_addr,
        input  register_write_data,
        output wb_write_complete
    );
endinterface

// File: rtl/register_file_responder.sv
// Architectural integer register file with busy scoreboard; accepts
// exactly one write per writeback episode and acknowledges it.
module register_file_responder #(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                               clk,
    input  logic                               reset,
    register_file_responder_if.slave           wb,
    output logic [NUM_REGS-1:0][XLEN-1:0]      register,
    input  logic [AW-1:0]                      rs1_addr,
    input  logic [AW-1:0]                      rs2_addr,
    output logic [XLEN-1:0]                    rs1_data,
    output logic [XLEN-1:0]                    rs2_data,
    input  logic                               reserve_enable,
    input  logic [AW-1:0]                      reserve_addr,
    output logic                               rs1_busy,
    output logic                               rs2_busy,
    output logic [NUM_REGS-1:0]                busy,
    output logic [63:0]                        writes_retired
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t              state;
    logic                accept;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic [NUM_REGS-1:0] busy_next;

    assign waddr  = wb.register_write_addr;
    assign wdata  = wb.register_write_data;
    assign accept = (state == IDLE) && wb.wb_module_enable
                  && wb.register_write_enable;

    assign wb.wb_write_complete = (state == ACK);

    // Reserve is applied after clear so a same-address collision stays busy.
    always_comb begin
        busy_next = busy;
        if (accept) begin
            busy_next[waddr] = 1'b0;
        end
        if (reserve_enable && (reserve_addr != '0)) begin
            busy_next[reserve_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            register       <= '0;
            busy           <= '0;
            writes_retired <= '0;
        end else begin
            busy <= busy_next;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (waddr != '0) begin
                            register[waddr] <= wdata;
                        end
                        writes_retired <= writes_retired + 64'd1;
                        state          <= ACK;
                    end
                end
                ACK: begin
                    if (!wb.wb_module_enable) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [XLEN-1:0] read_port(
        input logic [AW-1:0]                 a,
        input logic [NUM_REGS-1:0][XLEN-1:0] regs,
        input logic                          acc,
        input logic [AW-1:0]                 wa,
        input logic [XLEN-1:0]               wd
    );
        logic [XLEN-1:0] r;
        r = regs[a];
        if (BYPASS && acc && (wa == a)) begin
            r = wd;
        end
        if (a == '0) begin
            r = '0;
        end
        return r;
    endfunction

    assign rs1_data = read_port(rs1_addr, register, accept, waddr, wdata);
    assign rs2_data = read_port(rs2_addr, register, accept, waddr, wdata);

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];

endmodule
